// File: rtl/writeback_port_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | writeback_port_arbiter_if                                              |
// | Writeback, load-return and register-file write bundle for the arbiter. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface writeback_port_arbiter_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   wb_valid_i;
  logic [ADDR_W-1:0]      wb_rd_i;
  logic [XLEN-1:0]        wb_data_i;
  logic                   mem_valid_i;
  logic [ADDR_W-1:0]      mem_rd_i;
  logic [XLEN-1:0]        mem_data_i;
  logic                   mem_ready_o;
  logic                   stall_o;
  logic                   rf_we_o;
  logic [ADDR_W-1:0]      rf_rd_o;
  logic [XLEN-1:0]        rf_wd_o;
  logic [2**ADDR_W-1:0]   pend_mask_o;
  logic [CW-1:0]          pend_cnt_o;

  modport master (
    output wb_valid_i, wb_rd_i, wb_data_i, mem_valid_i, mem_rd_i, mem_data_i,
    input  mem_ready_o, stall_o, rf_we_o, rf_rd_o, rf_wd_o, pend_mask_o, pend_cnt_o
  );

  modport slave (
    input  wb_valid_i, wb_rd_i, wb_data_i, mem_valid_i, mem_rd_i, mem_data_i,
    output mem_ready_o, stall_o, rf_we_o, rf_rd_o, rf_wd_o, pend_mask_o, pend_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/writeback_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | writeback_port_arbiter                                                 |
// | Shares the RF write port between writeback and buffered load returns. |
// | Optional macro WB_BYPASS_EN: write load returns directly when idle.    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module writeback_port_arbiter #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 3
) (
  input  wire logic                clk,
  input  wire logic                rst,
  writeback_port_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = (MAX_DEFER < 2) ? 1 : $clog2(MAX_DEFER + 1);
  localparam logic [CW-1:0] C_DEPTH     = CW'(DEPTH);
  localparam logic [DW-1:0] C_MAX_DEFER = DW'(MAX_DEFER);

  logic [ADDR_W-1:0] fifo_rd_q [DEPTH];
  logic [ADDR_W-1:0] fifo_rd_d [DEPTH];
  logic [XLEN-1:0]   fifo_wd_q [DEPTH];
  logic [XLEN-1:0]   fifo_wd_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DW-1:0]     defer_q, defer_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]   rf_wd_q, rf_wd_d;

  logic wb_req, fifo_req, full, force_grant;
  logic fifo_grant, wb_grant, mem_ready, bypass, enq;

  assign wb_req      = bus.wb_valid_i && (bus.wb_rd_i != '0);
  assign fifo_req    = (count_q != '0);
  assign full        = (count_q == C_DEPTH);
  assign force_grant = fifo_req && (defer_q == C_MAX_DEFER);
  assign fifo_grant  = fifo_req && (force_grant || !wb_req);
  assign wb_grant    = wb_req && !fifo_grant;
  assign mem_ready   = !rst && !full;

`ifdef WB_BYPASS_EN
  // An idle port lets a load return skip the FIFO entirely.
  assign bypass = !rst && !fifo_req && !wb_req && bus.mem_valid_i && (bus.mem_rd_i != '0);
`else
  assign bypass = 1'b0;
`endif

  assign enq = bus.mem_valid_i && mem_ready && (bus.mem_rd_i != '0) && !bypass;

  always_comb begin
    fifo_rd_d = fifo_rd_q;
    fifo_wd_d = fifo_wd_q;
    valid_d   = valid_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (enq) begin
      fifo_rd_d[wr_ptr_q] = bus.mem_rd_i;
      fifo_wd_d[wr_ptr_q] = bus.mem_data_i;
      valid_d[wr_ptr_q]   = 1'b1;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    if (fifo_grant) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(enq) - CW'(fifo_grant);
  end

  // Defer only accumulates while the head is waiting behind writeback.
  always_comb begin
    defer_d = defer_q;
    if (!fifo_req || fifo_grant) begin
      defer_d = '0;
    end else if (defer_q != C_MAX_DEFER) begin
      defer_d = defer_q + 1'b1;
    end
  end

  always_comb begin
    rf_we_d = fifo_grant || wb_grant || bypass;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    if (fifo_grant) begin
      rf_rd_d = fifo_rd_q[rd_ptr_q];
      rf_wd_d = fifo_wd_q[rd_ptr_q];
    end else if (wb_grant) begin
      rf_rd_d = bus.wb_rd_i;
      rf_wd_d = bus.wb_data_i;
    end else if (bypass) begin
      rf_rd_d = bus.mem_rd_i;
      rf_wd_d = bus.mem_data_i;
    end
  end

  always_ff @(posedge clk) begin
    fifo_rd_q <= fifo_rd_d;
    fifo_wd_q <= fifo_wd_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      defer_q  <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_wd_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      defer_q  <= defer_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_wd_q  <= rf_wd_d;
    end
  end

  logic [2**ADDR_W-1:0] pend_mask;

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        pend_mask[fifo_rd_q[i]] = 1'b1;
      end
    end
  end

  assign bus.mem_ready_o = mem_ready;
  assign bus.stall_o     = !rst && force_grant && wb_req;
  assign bus.rf_we_o     = rf_we_q;
  assign bus.rf_rd_o     = rf_rd_q;
  assign bus.rf_wd_o     = rf_wd_q;
  assign bus.pend_mask_o = pend_mask;
  assign bus.pend_cnt_o  = count_q;
endmodule
`default_nettype wire

// File: tb/tb_writeback_port_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_writeback_port_arbiter                                              |
// | Directed bench with an RF-write scoreboard for writeback_port_arbiter. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_writeback_port_arbiter;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [ADDR_W+XLEN-1:0] sb [$];

  always #5 clk = ~clk;

  writeback_port_arbiter_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  writeback_port_arbiter #(
    .XLEN(XLEN), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_DEFER(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    bus.wb_valid_i = v;
    bus.wb_rd_i    = rd;
    bus.wb_data_i  = d;
  endtask

  task automatic drive_mem(input logic v, input logic [ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    bus.mem_valid_i = v;
    bus.mem_rd_i    = rd;
    bus.mem_data_i  = d;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] rd, input logic [XLEN-1:0] d);
    sb.push_back({rd, d});
  endtask

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.rf_we_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rf_spurious_we", bus.rf_we_o, 1'b0);
      end else begin
        logic [ADDR_W+XLEN-1:0] e;
        e = sb.pop_front();
        chk("rf_write", {bus.rf_rd_o, bus.rf_wd_o}, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_wb(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    step();
    step();
    chk("rst_rf_we", bus.rf_we_o, 1'b0);
    chk("rst_rf_rd", bus.rf_rd_o, '0);
    chk("rst_rf_wd", bus.rf_wd_o, '0);
    chk("rst_cnt", bus.pend_cnt_o, '0);
    chk("rst_mask", bus.pend_mask_o, '0);
    chk("rst_ready", bus.mem_ready_o, 1'b0);
    chk("rst_stall", bus.stall_o, 1'b0);
    rst = 1'b0;
    #2 chk("ready_after_rst", bus.mem_ready_o, 1'b1);

    // Plain writeback, one-cycle latency
    drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    #1 chk("t1_stall", bus.stall_o, 1'b0);
    step();
    chk("t1_we", bus.rf_we_o, 1'b1);
    chk("t1_rd", bus.rf_rd_o, 5'd5);
    chk("t1_wd", bus.rf_wd_o, 32'hDEAD_BEEF);
    drive_wb(1'b0, '0, '0);

    // Single load return with an idle writeback stage
    drive_mem(1'b1, 5'd7, 32'h12);
    expect_wr(5'd7, 32'h12);
    #1 chk("t2_ready", bus.mem_ready_o, 1'b1);
    step();
    drive_mem(1'b0, '0, '0);
`ifdef WB_BYPASS_EN
    chk("t2_byp_we", bus.rf_we_o, 1'b1);
    chk("t2_byp_rd", bus.rf_rd_o, 5'd7);
    chk("t2_byp_mask", bus.pend_mask_o, '0);
    step();
`else
    chk("t2_mask_set", bus.pend_mask_o, 32'h0000_0080);
    chk("t2_cnt", bus.pend_cnt_o, 1);
    chk("t2_we_early", bus.rf_we_o, 1'b0);
    step();
    chk("t2_we", bus.rf_we_o, 1'b1);
    chk("t2_rd", bus.rf_rd_o, 5'd7);
`endif
    chk("t2_mask_clr", bus.pend_mask_o, '0);
    chk("t2_cnt_clr", bus.pend_cnt_o, 0);

    // Defer limit: three writeback wins, then a forced FIFO grant
    drive_wb(1'b1, 5'd1, 32'hA000_0001);
    drive_mem(1'b1, 5'd9, 32'h99);
    expect_wr(5'd1, 32'hA000_0001);
    #1 chk("t3_stall_a", bus.stall_o, 1'b0);
    step();
    drive_mem(1'b0, '0, '0);
    chk("t3_cnt", bus.pend_cnt_o, 1);
    for (int k = 2; k <= 4; k++) begin
      drive_wb(1'b1, 5'(k), 32'hA000_0000 + k);
      expect_wr(5'(k), 32'hA000_0000 + k);
      #1 chk("t3_stall_wb", bus.stall_o, 1'b0);
      step();
    end
    drive_wb(1'b1, 5'd5, 32'hA000_0005);
    expect_wr(5'd9, 32'h99);
    expect_wr(5'd5, 32'hA000_0005);
    #1 chk("t3_forced_stall", bus.stall_o, 1'b1);
    step();
    chk("t3_forced_rd", bus.rf_rd_o, 5'd9);
    chk("t3_cnt_clr", bus.pend_cnt_o, 0);
    #1 chk("t3_held_stall", bus.stall_o, 1'b0);
    step();
    chk("t3_held_rd", bus.rf_rd_o, 5'd5);
    drive_wb(1'b0, '0, '0);

    // Fill the FIFO while writeback is busy; fifth return is refused
    for (int k = 1; k <= 4; k++) begin
      drive_wb(1'b1, 5'(9 + k), 32'hB000_0000 + k);
      drive_mem(1'b1, 5'(k), 32'h100 + k);
      expect_wr(5'(9 + k), 32'hB000_0000 + k);
      #1 chk("t4_ready", bus.mem_ready_o, 1'b1);
      chk("t4_stall", bus.stall_o, 1'b0);
      step();
    end
    drive_wb(1'b1, 5'd14, 32'hB000_000E);
    drive_mem(1'b1, 5'd5, 32'h105);
    expect_wr(5'd1, 32'h101);
    expect_wr(5'd14, 32'hB000_000E);
    #1 chk("t4_full_ready", bus.mem_ready_o, 1'b0);
    chk("t4_full_cnt", bus.pend_cnt_o, 4);
    chk("t4_full_stall", bus.stall_o, 1'b1);
    chk("t4_full_mask", bus.pend_mask_o, 32'h0000_001E);
    step();
    drive_mem(1'b0, '0, '0);
    chk("t4_cnt3", bus.pend_cnt_o, 3);
    chk("t4_mask3", bus.pend_mask_o, 32'h0000_001C);
    #1 chk("t4_held_stall", bus.stall_o, 1'b0);
    step();
    drive_wb(1'b0, '0, '0);
    for (int k = 2; k <= 4; k++) begin
      expect_wr(5'(k), 32'h100 + k);
      step();
    end
    chk("t4_drained_cnt", bus.pend_cnt_o, 0);
    chk("t4_drained_mask", bus.pend_mask_o, '0);

    // x0 destinations never touch the port or the FIFO
    drive_wb(1'b1, 5'd0, 32'hFFFF);
    drive_mem(1'b1, 5'd0, 32'hEEEE);
    #1 chk("t5_stall", bus.stall_o, 1'b0);
    chk("t5_ready", bus.mem_ready_o, 1'b1);
    step();
    drive_wb(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    chk("t5_we", bus.rf_we_o, 1'b0);
    chk("t5_cnt", bus.pend_cnt_o, 0);
    chk("t5_mask", bus.pend_mask_o, '0);

    // Duplicate rd in the FIFO, plus simultaneous enqueue/dequeue
    drive_wb(1'b1, 5'd20, 32'hC000_0014);
    drive_mem(1'b1, 5'd6, 32'h1);
    expect_wr(5'd20, 32'hC000_0014);
    step();
    drive_wb(1'b1, 5'd21, 32'hC000_0015);
    drive_mem(1'b1, 5'd6, 32'h2);
    expect_wr(5'd21, 32'hC000_0015);
    step();
    chk("t7_cnt2", bus.pend_cnt_o, 2);
    chk("t7_mask6", bus.pend_mask_o, 32'h0000_0040);
    drive_wb(1'b0, '0, '0);
    drive_mem(1'b1, 5'd8, 32'h3);
    expect_wr(5'd6, 32'h1);
    #1 chk("t7_ready", bus.mem_ready_o, 1'b1);
    step();
    drive_mem(1'b0, '0, '0);
    chk("t7_cnt_same", bus.pend_cnt_o, 2);
    chk("t7_mask_dup", bus.pend_mask_o, 32'h0000_0140);
    expect_wr(5'd6, 32'h2);
    step();
    chk("t7_mask8", bus.pend_mask_o, 32'h0000_0100);
    expect_wr(5'd8, 32'h3);
    step();
    chk("t7_cnt0", bus.pend_cnt_o, 0);
    chk("t7_mask0", bus.pend_mask_o, '0);

    // Reset with three loads queued
    for (int k = 0; k < 3; k++) begin
      drive_wb(1'b1, 5'(22 + k), 32'hD000_0000 + k);
      drive_mem(1'b1, 5'(11 + k), 32'h200 + k);
      expect_wr(5'(22 + k), 32'hD000_0000 + k);
      step();
    end
    drive_mem(1'b0, '0, '0);
    chk("t6_cnt3", bus.pend_cnt_o, 3);
    chk("t6_mask3", bus.pend_mask_o, 32'h0000_3800);
    rst = 1'b1;
    drive_wb(1'b1, 5'd25, 32'hD000_0019);
    #1 chk("t6_rst_ready", bus.mem_ready_o, 1'b0);
    chk("t6_rst_stall", bus.stall_o, 1'b0);
    step();
    chk("t6_we", bus.rf_we_o, 1'b0);
    chk("t6_cnt", bus.pend_cnt_o, 0);
    chk("t6_mask", bus.pend_mask_o, '0);
    rst = 1'b0;
    drive_wb(1'b0, '0, '0);
    step();
    chk("t6_no_replay", bus.rf_we_o, 1'b0);
    step();
    step();
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
